// File: rtl/demux2_sync.sv
// Clocked 1-to-2 demultiplexer for 4-phase bundled-data channels: a control token steers one data token.
// Optional macro DEMUX2_SYNC_EN adds 2-flop synchronizers on r_i, rctl_i, a_o and a1_o.
module demux2_sync #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         r_i,
   output logic         a_i,
   input  logic [N-1:0] d_i,
   input  logic         rctl_i,
   input  logic         dctl_i,
   output logic         actl_i,
   output logic         r_o,
   input  logic         a_o,
   output logic [N-1:0] d_o,
   output logic         r1_o,
   input  logic         a1_o,
   output logic [N-1:0] d1_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] REQ   = 2'd2;
   localparam logic [1:0] ACK   = 2'd3;

   logic [1:0]   state;
   logic [N-1:0] data_q;
   logic         sel_q;
   logic         ack_q;

   // Sampled views of the handshake inputs seen by the FSM.
   logic rs, rcs, as0, as1;

`ifdef DEMUX2_SYNC_EN
   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {r_i, rctl_i, a_o, a1_o};
         sync_q <= meta_q;
      end
   end

   assign {rs, rcs, as0, as1} = sync_q;
`else
   assign {rs, rcs, as0, as1} = {r_i, rctl_i, a_o, a1_o};
`endif

   logic sel_ack;
   assign sel_ack = sel_q ? as1 : as0;

   // Both acknowledges come from one flop, so they rise and fall together.
   assign a_i    = ack_q;
   assign actl_i = ack_q;

   // NOTE: every register here, including the data holding registers, is reset and updated with
   // non-blocking assignments so all flops see the pre-edge values of each other.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         data_q <= '0;
         sel_q  <= 1'b0;
         ack_q  <= 1'b0;
         r_o    <= 1'b0;
         r1_o   <= 1'b0;
         d_o    <= '0;
         d1_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rs && rcs) begin
                  data_q <= d_i;
                  sel_q  <= dctl_i;
                  state  <= SETUP;
               end
            end

            SETUP: begin
               d_o   <= data_q;
               d1_o  <= data_q;
               state <= REQ;
            end

            // The request rises on the first edge in REQ, giving the data a full cycle of setup.
            REQ: begin
               if (!(r_o || r1_o)) begin
                  if (sel_q) r1_o <= 1'b1;
                  else       r_o  <= 1'b1;
               end else if (sel_ack) begin
                  r_o   <= 1'b0;
                  r1_o  <= 1'b0;
                  ack_q <= 1'b1;
                  state <= ACK;
               end
            end

            ACK: begin
               if (!rs && !rcs && !sel_ack) begin
                  ack_q <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux2_sync.sv
// Randomized self-checking bench for demux2_sync (N=8); acts as producer, control source and both consumers.
module tb_demux2_sync;

   localparam int N = 8;
`ifdef DEMUX2_SYNC_EN
   localparam int X = 2;
`else
   localparam int X = 0;
`endif
   // Handshake latencies in cycles, measured from the negedge where the stimulus changes.
   localparam int REQ_LAT = 3 + X;
   localparam int ACK_LAT = 1 + X;
   localparam int BOUND   = 50;

   logic         clk;
   logic         rst_n;
   logic         r_i, rctl_i, dctl_i, a_o, a1_o;
   logic [N-1:0] d_i;
   logic         a_i, actl_i, r_o, r1_o;
   logic [N-1:0] d_o, d1_o;

   int checks      = 0;
   int errors      = 0;
   int tokens_done = 0;
   int overlap     = 0;
   int ai_rises    = 0;
   int actl_rises  = 0;
   logic ai_prev   = 1'b0;
   logic actl_prev = 1'b0;

   demux2_sync #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst_n),
      .r_i    (r_i),
      .a_i    (a_i),
      .d_i    (d_i),
      .rctl_i (rctl_i),
      .dctl_i (dctl_i),
      .actl_i (actl_i),
      .r_o    (r_o),
      .a_o    (a_o),
      .d_o    (d_o),
      .r1_o   (r1_o),
      .a1_o   (a1_o),
      .d1_o   (d1_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Whole-run observations: output requests must be exclusive, acknowledges pulse once per token.
   always @(negedge clk) begin
      if (r_o && r1_o) overlap++;
      if (a_i && !ai_prev) ai_rises++;
      if (actl_i && !actl_prev) actl_rises++;
      ai_prev   = a_i;
      actl_prev = actl_i;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_ack(input logic sel, input logic val);
      if (sel) a1_o = val;
      else     a_o  = val;
   endtask

   task automatic wait_req(input logic [N-1:0] data, input logic sel);
      int cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(r_o || r1_o) && cnt < BOUND);
      check("req_latency", cnt, REQ_LAT);
      check("req_route", {r_o, r1_o}, sel ? 2'b01 : 2'b10);
      check("req_data", {d_o, d1_o}, {data, data});
      check("no_early_ack", {a_i, actl_i}, 2'b00);
   endtask

   task automatic start_token(input logic [N-1:0] data, input logic sel);
      @(negedge clk);
      d_i    = data;
      dctl_i = sel;
      r_i    = 1'b1;
      rctl_i = 1'b1;
      wait_req(data, sel);
   endtask

   task automatic finish_token(input logic [N-1:0] data, input logic sel, input int ack_dly,
                               input int tr, input int tc, input int ta, input bit stray);
      int cnt;
      int maxt;
      repeat (ack_dly) @(negedge clk);
      if (stray) begin
         set_ack(!sel, 1'b1);
         @(negedge clk);
         set_ack(!sel, 1'b0);
         repeat (X + 2) @(negedge clk);
         check("stray_ack_ignored", {a_i, sel ? r1_o : r_o}, 2'b01);
      end
      check("req_held", sel ? r1_o : r_o, 1'b1);
      set_ack(sel, 1'b1);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!a_i && cnt < BOUND);
      check("ack_latency", cnt, ACK_LAT);
      check("ack_state", {actl_i, r_o, r1_o}, 3'b100);
      check("data_hold", {d_o, d1_o}, {data, data});

      maxt = tr;
      if (tc > maxt) maxt = tc;
      if (ta > maxt) maxt = ta;
      for (int t = 0; t <= maxt; t++) begin
         if (t == tr) r_i = 1'b0;
         if (t == tc) rctl_i = 1'b0;
         if (t == ta) set_ack(sel, 1'b0);
         if (t < maxt) begin
            @(negedge clk);
            check("ack_hold", {a_i, actl_i}, 2'b11);
         end
      end
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (a_i && cnt < BOUND);
      check("release_latency", cnt, ACK_LAT);
      check("actl_release", actl_i, 1'b0);
      tokens_done++;
   endtask

   task automatic run_token(input logic [N-1:0] data, input logic sel, input int ack_dly,
                            input int tr, input int tc, input int ta, input bit stray);
      start_token(data, sel);
      finish_token(data, sel, ack_dly, tr, tc, ta, stray);
   endtask

   initial begin
      logic [N-1:0] rd;
      rst_n  = 1'b0;
      r_i    = 1'b1;
      rctl_i = 1'b1;
      dctl_i = 1'b0;
      d_i    = 8'hA5;
      a_o    = 1'b0;
      a1_o   = 1'b0;

      // Reset held with both requests up: nothing may move.
      repeat (3) @(negedge clk);
      check("reset_outputs", {a_i, actl_i, r_o, r1_o, d_o, d1_o}, '0);
      rst_n = 1'b1;
      wait_req(8'hA5, 1'b0);
      finish_token(8'hA5, 1'b0, 0, 0, 0, 0, 1'b0);

      // Route to output 0 with a stray ack on output 1 during REQ.
      run_token(8'hA5, 1'b0, 1, 0, 0, 0, 1'b1);

      // Route to output 1; control drops first, data request two cycles later.
      run_token(8'h3C, 1'b1, 0, 2, 0, 1, 1'b0);

      // Lone data request in IDLE must never be acknowledged.
      @(negedge clk);
      r_i    = 1'b1;
      rctl_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stray_idle", {a_i, actl_i, r_o, r1_o}, 4'b0000);
      end
      r_i = 1'b0;
      repeat (X + 2) @(negedge clk);

      // Back-to-back tokens with alternating control and random handshake timing.
      for (int i = 0; i < 20; i++) begin
         rd = N'($urandom);
         run_token(rd, i[0], int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end

      // Reset while output 1 is requesting: everything drops at once, the token is lost.
      start_token(8'h5A, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_req", {a_i, actl_i, r_o, r1_o, d_o, d1_o}, '0);
      r_i    = 1'b0;
      rctl_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_token(8'h77, 1'b1, 0, 0, 0, 0, 1'b0);
      run_token(8'hC3, 1'b0, 2, 1, 1, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("requests_exclusive", overlap, 0);
      check("a_i_pulses", ai_rises, tokens_done);
      check("actl_i_pulses", actl_rises, tokens_done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
